// File: rtl/fp_alu_arbiter_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : fp_alu_arbiter_if
// Purpose  : Bundles the requester bus and the shared-ALU handshake used by
//            fp_alu_arbiter. The slave modport is the arbiter's view; the
//            master modport is the requesters-plus-ALU side.
// Revision : 1.0  initial release
// ============================================================================
interface fp_alu_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int N       = 32
);
    // requester side
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*N-1:0] req_a;
    logic [NUM_REQ*N-1:0] req_b;
    logic [NUM_REQ*2-1:0] req_op;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [N-1:0]         rsp_data;
    logic                 rsp_err;

    // ALU side
    logic [N-1:0]         alu_a;
    logic [N-1:0]         alu_b;
    logic [1:0]           alu_opcode;
    logic                 alu_start;
    logic [N-1:0]         alu_c;
    logic                 alu_done;

    modport slave (
        input  req, req_a, req_b, req_op, alu_c, alu_done,
        output gnt, rsp_valid, rsp_data, rsp_err,
               alu_a, alu_b, alu_opcode, alu_start
    );

    modport master (
        output req, req_a, req_b, req_op, alu_c, alu_done,
        input  gnt, rsp_valid, rsp_data, rsp_err,
               alu_a, alu_b, alu_opcode, alu_start
    );
endinterface
`default_nettype wire

// File: rtl/fp_alu_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : fp_alu_arbiter
// Purpose  : Round-robin sharing of one start/done fixed-point ALU among
//            NUM_REQ requesters, one operation in flight, with a watchdog
//            that returns an error response if the ALU never answers.
// Revision : 1.0  initial release
// ============================================================================
module fp_alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int N       = 32,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    fp_alu_arbiter_if.slave bus
);

    localparam int               PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [PTR_W:0]   REQ_CNT  = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [PTR_W-1:0]   win_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [N-1:0]       rsp_data_q;
    logic               rsp_err_q;
    logic [N-1:0]       alu_a_q;
    logic [N-1:0]       alu_b_q;
    logic [1:0]         alu_op_q;
    logic               alu_start_q;

    logic [NUM_REQ-1:0] req_rot;
    logic [PTR_W-1:0]   off_d;
    logic [PTR_W:0]     sum_d;
    logic [PTR_W-1:0]   win_d;
    logic [NUM_REQ-1:0] gnt_d;
    logic [PTR_W-1:0]   rr_next_d;

    logic [N-1:0]       req_a_arr  [NUM_REQ];
    logic [N-1:0]       req_b_arr  [NUM_REQ];
    logic [1:0]         req_op_arr [NUM_REQ];

    // Split the packed requester buses so the winner can be selected by index.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_a_arr[gi]  = bus.req_a[gi*N +: N];
        assign req_b_arr[gi]  = bus.req_b[gi*N +: N];
        assign req_op_arr[gi] = bus.req_op[gi*2 +: 2];
    end

    // Rotate requests so bit 0 is the requester at rr_ptr; the lowest set bit
    // of the rotated vector is then the round-robin winner's offset.
    assign req_rot = NUM_REQ'({bus.req, bus.req} >> rr_ptr_q);

    // Winner = rr_ptr + offset of first pending request, wrapped at NUM_REQ.
    always_comb begin
        off_d = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                off_d = PTR_W'(i);
            end
        end
        sum_d = {1'b0, rr_ptr_q} + {1'b0, off_d};
        if (sum_d >= REQ_CNT) begin
            sum_d = sum_d - REQ_CNT;
        end
    end

    assign win_d     = sum_d[PTR_W-1:0];
    assign gnt_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_d;
    // After serving the winner it drops to lowest priority next round.
    assign rr_next_d = (win_q == LAST_IDX) ? '0 : win_q + 1'b1;

    // Transaction FSM; every output is a register updated on the transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            win_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            alu_start_q <= 1'b0;
        end else begin
            // Pulses default low; they are raised only on the entering edge.
            alu_start_q <= 1'b0;
            rsp_valid_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (|bus.req) begin
                        win_q       <= win_d;
                        gnt_q       <= gnt_d;
                        alu_a_q     <= req_a_arr[win_d];
                        alu_b_q     <= req_b_arr[win_d];
                        alu_op_q    <= req_op_arr[win_d];
                        alu_start_q <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // A done seen here belongs to nothing we issued; ignore it.
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (bus.alu_done) begin
                        rsp_data_q  <= bus.alu_c;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= gnt_q;
                        state_q     <= S_RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= gnt_q;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    gnt_q    <= '0;
                    rr_ptr_q <= rr_next_d;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_opcode = alu_op_q;
    assign bus.alu_start  = alu_start_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_alu_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fp_alu_arbiter
// Purpose  : Directed self-checking bench for fp_alu_arbiter; the bench plays
//            both the requesters and the shared ALU.
// Revision : 1.0  initial release
// ============================================================================
module tb_fp_alu_arbiter;

    localparam int NR = 4;
    localparam int W  = 32;
    localparam int TO = 8;

    logic clk;
    logic rst_n;
    int   checks  = 0;
    int   passes  = 0;
    int   n_start = 0;
    int   n_rsp   = 0;
    int   n_lat;
    int   rsp_before;
    int   start_before;

    fp_alu_arbiter_if #(.NUM_REQ(NR), .N(W)) bus ();

    fp_alu_arbiter #(.NUM_REQ(NR), .N(W), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count start pulses and response pulses mid-cycle.
    always @(negedge clk) begin
        if (bus.alu_start)  n_start <= n_start + 1;
        if (|bus.rsp_valid) n_rsp   <= n_rsp + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"},   64'(bus.gnt),        64'd0);
        chk({tag, "_rspv"},  64'(bus.rsp_valid),  64'd0);
        chk({tag, "_rspd"},  64'(bus.rsp_data),   64'd0);
        chk({tag, "_rspe"},  64'(bus.rsp_err),    64'd0);
        chk({tag, "_a"},     64'(bus.alu_a),      64'd0);
        chk({tag, "_b"},     64'(bus.alu_b),      64'd0);
        chk({tag, "_op"},    64'(bus.alu_opcode), 64'd0);
        chk({tag, "_start"}, 64'(bus.alu_start),  64'd0);
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
        bus.req_op[i*2 +: 2] = op;
    endtask

    // One complete transaction for requester idx, ALU answering after w extra
    // WAIT cycles with result c. Caller has already set req.
    task automatic serve(input int idx, input int w, input logic [31:0] ea,
                         input logic [31:0] eb, input logic [1:0] eo,
                         input logic [31:0] c);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        step();
        chk("issue_gnt",   64'(bus.gnt),        64'(oh));
        chk("issue_start", 64'(bus.alu_start),  64'd1);
        chk("issue_a",     64'(bus.alu_a),      64'(ea));
        chk("issue_b",     64'(bus.alu_b),      64'(eb));
        chk("issue_op",    64'(bus.alu_opcode), 64'(eo));
        step();
        chk("start_pulse", 64'(bus.alu_start),  64'd0);
        repeat (w) step();
        bus.alu_done = 1'b1;
        bus.alu_c    = c;
        step();
        chk("rsp_valid",   64'(bus.rsp_valid),  64'(oh));
        chk("rsp_data",    64'(bus.rsp_data),   64'(c));
        chk("rsp_err",     64'(bus.rsp_err),    64'd0);
        bus.alu_done = 1'b0;
        step();
        chk("rsp_end",     64'(bus.rsp_valid),  64'd0);
        chk("gnt_clr",     64'(bus.gnt),        64'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.req      = '0;
        bus.req_a    = '0;
        bus.req_b    = '0;
        bus.req_op   = '0;
        bus.alu_c    = '0;
        bus.alu_done = 1'b0;
        repeat (2) step();
        chk_zero("reset");
        rst_n = 1'b1;
        step();

        // 1: single request, 1.5 + 2.25 = 3.75 in Q15
        set_ops(0, 32'h0000C000, 32'h00012000, 2'b00);
        bus.req = 4'b0001;
        serve(0, 2, 32'h0000C000, 32'h00012000, 2'b00, 32'h0001E000);
        bus.req = 4'b0000;
        chk("t1_nstart", 64'(n_start), 64'd1);
        chk("t1_nrsp",   64'(n_rsp),   64'd1);

        // 2: all requesting from a fresh pointer -> 0,1,2,3,0
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < NR; i++) set_ops(i, 32'h100 + i, 32'h200 + i, 2'(i));
        bus.req = 4'b1111;
        serve(0, 0, 32'h100, 32'h200, 2'd0, 32'hA0);
        serve(1, 0, 32'h101, 32'h201, 2'd1, 32'hA1);
        serve(2, 1, 32'h102, 32'h202, 2'd2, 32'hA2);
        serve(3, 0, 32'h103, 32'h203, 2'd3, 32'hA3);
        serve(0, 0, 32'h100, 32'h200, 2'd0, 32'hA4);
        bus.req = 4'b0000;
        chk("t2_nstart", 64'(n_start), 64'd6);

        // 3: ALU never answers -> error response after TO WAIT cycles
        bus.req = 4'b0010;
        step();
        chk("t3_gnt", 64'(bus.gnt), 64'b0010);
        n_lat = 0;
        do begin
            step();
            n_lat++;
        end while (bus.rsp_valid == 4'b0000 && n_lat < 4 * TO);
        chk("t3_latency", 64'(n_lat),          64'(TO + 1));
        chk("t3_rspv",    64'(bus.rsp_valid),  64'b0010);
        chk("t3_err",     64'(bus.rsp_err),    64'd1);
        chk("t3_data",    64'(bus.rsp_data),   64'd0);
        bus.req = 4'b0000;
        step();
        chk("t3_err_hold", 64'(bus.rsp_err), 64'd1);
        bus.req = 4'b0100;
        serve(2, 0, 32'h102, 32'h202, 2'd2, 32'h55AA);
        bus.req = 4'b0000;

        // 4: done in IDLE and ISSUE ignored; done on the last WAIT cycle wins
        bus.alu_done = 1'b1;
        bus.alu_c    = 32'hDEAD;
        repeat (2) step();
        chk("t4_idle_rsp",   64'(bus.rsp_valid), 64'd0);
        chk("t4_idle_start", 64'(bus.alu_start), 64'd0);
        bus.req = 4'b1000;
        step();
        chk("t4_gnt", 64'(bus.gnt), 64'b1000);
        step();
        chk("t4_issue_rsp", 64'(bus.rsp_valid), 64'd0);
        bus.alu_done = 1'b0;
        repeat (TO - 1) step();
        chk("t4_no_early", 64'(bus.rsp_valid), 64'd0);
        bus.alu_done = 1'b1;
        bus.alu_c    = 32'h00BEEF00;
        step();
        chk("t4_rspv", 64'(bus.rsp_valid), 64'b1000);
        chk("t4_err",  64'(bus.rsp_err),   64'd0);
        chk("t4_data", 64'(bus.rsp_data),  64'h00BEEF00);
        bus.alu_done = 1'b0;
        bus.req      = 4'b0000;
        step();

        // 6: req[1] withdrawn before grant; operands captured at grant
        bus.req = 4'b0001;
        step();
        chk("t6_gnt0", 64'(bus.gnt), 64'b0001);
        bus.req = 4'b1011;
        step();
        bus.req      = 4'b1001;
        bus.alu_done = 1'b1;
        bus.alu_c    = 32'h11;
        step();
        chk("t6_rsp0", 64'(bus.rsp_valid), 64'b0001);
        bus.alu_done = 1'b0;
        bus.req      = 4'b1000;
        step();
        step();
        chk("t6_gnt3", 64'(bus.gnt),   64'b1000);
        chk("t6_a3",   64'(bus.alu_a), 64'h103);
        set_ops(3, 32'hFFFF0000, 32'hFFFF1111, 2'd0);
        step();
        chk("t6_a_hold",  64'(bus.alu_a),      64'h103);
        chk("t6_b_hold",  64'(bus.alu_b),      64'h203);
        chk("t6_op_hold", 64'(bus.alu_opcode), 64'd3);
        bus.alu_done = 1'b1;
        bus.alu_c    = 32'h33;
        step();
        chk("t6_rsp3", 64'(bus.rsp_valid), 64'b1000);
        bus.alu_done = 1'b0;
        bus.req      = 4'b0000;
        start_before = n_start;
        repeat (3) step();
        chk("t6_no_req1", 64'(n_start), 64'(start_before));
        chk("t6_gnt_idle", 64'(bus.gnt), 64'd0);
        bus.req = 4'b0100;
        serve(2, 0, 32'h102, 32'h202, 2'd2, 32'h22);
        bus.req = 4'b0000;

        // 5: reset during WAIT aborts, pointer returns to 0
        bus.req = 4'b0100;
        step();
        chk("t5_gnt", 64'(bus.gnt), 64'b0100);
        step();
        step();
        rsp_before = n_rsp;
        rst_n = 1'b0;
        #1;
        chk_zero("t5_async");
        step();
        step();
        rst_n        = 1'b1;
        bus.req      = 4'b0000;
        bus.alu_done = 1'b1;
        step();
        chk("t5_no_rsp", 64'(n_rsp), 64'(rsp_before));
        bus.alu_done = 1'b0;
        bus.req      = 4'b1100;
        serve(2, 0, 32'h102, 32'h202, 2'd2, 32'h77);
        bus.req = 4'b0000;
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
